// File: rtl/mem_arb_pkg.sv
// Shared types for the I-cache/D-cache block-memory arbiter: FSM encoding,
// requester identifiers and the block-width helper.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GNT0 = 2'd1,
    ST_GNT1 = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_REQ   = 2;
  localparam logic        REQ_ICACHE = 1'b0;
  localparam logic        REQ_DCACHE = 1'b1;

  localparam int unsigned BIT_W_DEF   = 32;
  localparam int unsigned BLOCK_W_DEF = BIT_W_DEF * 4;

  function automatic int unsigned block_w(input int unsigned bit_w);
    return bit_w * 4;
  endfunction

  function automatic arb_state_e gnt_state(input logic id);
    return (id == REQ_DCACHE) ? ST_GNT1 : ST_GNT0;
  endfunction

endpackage

// File: rtl/mem_req_arbiter_rr_arb2.sv
// Two-way round-robin pick. The pointer names the preferred requester and moves
// to the other side whenever the current owner completes a transaction.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic [1:0] req_i,
  input  logic       done_i,
  input  logic       done_id_i,
  output logic [1:0] pick_o
);

  logic ptr_q, ptr_d;

  always_comb begin
    pick_o = 2'b00;
    unique case (req_i)
      2'b01:   pick_o = 2'b01;
      2'b10:   pick_o = 2'b10;
      2'b11:   pick_o = (ptr_q == REQ_DCACHE) ? 2'b10 : 2'b01;
      default: pick_o = 2'b00;
    endcase
  end

  always_comb begin
    ptr_d = ptr_q;
    if (done_i) ptr_d = ~done_id_i;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) ptr_q <= REQ_ICACHE;
    else          ptr_q <= ptr_d;
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// Shares one block-memory port between the I-cache (r0) and D-cache (r1).
// Registered one-hot grant, round-robin between owners, optional lock for a pair.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned BIT_W  = 32,
  parameter int unsigned ADDR_W = 32
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_r0_cen,
  input  logic                    i_r0_wen,
  input  logic                    i_r0_lock,
  input  logic [ADDR_W-1:0]       i_r0_addr,
  input  logic [block_w(BIT_W)-1:0] i_r0_wdata,
  output logic                    o_r0_stall,
  input  logic                    i_r1_cen,
  input  logic                    i_r1_wen,
  input  logic                    i_r1_lock,
  input  logic [ADDR_W-1:0]       i_r1_addr,
  input  logic [block_w(BIT_W)-1:0] i_r1_wdata,
  output logic                    o_r1_stall,
  output logic [block_w(BIT_W)-1:0] o_rdata,
  output logic                    o_mem_cen,
  output logic                    o_mem_wen,
  output logic [ADDR_W-1:0]       o_mem_addr,
  output logic [block_w(BIT_W)-1:0] o_mem_wdata,
  input  logic [block_w(BIT_W)-1:0] i_mem_rdata,
  input  logic                    i_mem_stall,
  output logic [1:0]              o_grant
);

  localparam int unsigned BLOCK_W = block_w(BIT_W);

  arb_state_e         state_q, state_d;
  logic               locked_q, locked_d;
  logic               in_gnt, own, done;
  logic               cen_sel, wen_sel, lock_sel;
  logic [ADDR_W-1:0]  addr_sel;
  logic [BLOCK_W-1:0] wdata_sel;
  logic [1:0]         pick;

  // Owner-side request mux; the non-owner never reaches the memory port.
  always_comb begin
    in_gnt    = (state_q != ST_IDLE);
    own       = (state_q == ST_GNT1);
    cen_sel   = own ? i_r1_cen   : i_r0_cen;
    wen_sel   = own ? i_r1_wen   : i_r0_wen;
    lock_sel  = own ? i_r1_lock  : i_r0_lock;
    addr_sel  = own ? i_r1_addr  : i_r0_addr;
    wdata_sel = own ? i_r1_wdata : i_r0_wdata;
    done      = in_gnt && cen_sel && !i_mem_stall;
  end

  assign o_mem_cen   = in_gnt && cen_sel;
  assign o_mem_wen   = in_gnt && wen_sel;
  assign o_mem_addr  = in_gnt ? addr_sel  : '0;
  assign o_mem_wdata = in_gnt ? wdata_sel : '0;
  assign o_rdata     = i_mem_rdata;
  assign o_grant     = {state_q == ST_GNT1, state_q == ST_GNT0};

  assign o_r0_stall = i_r0_cen && !((state_q == ST_GNT0) && !i_mem_stall);
  assign o_r1_stall = i_r1_cen && !((state_q == ST_GNT1) && !i_mem_stall);

  rr_arb2 u_rr (
    .clk_i     (i_clk),
    .rst_n_i   (i_rst_n),
    .req_i     ({i_r1_cen, i_r0_cen}),
    .done_i    (done),
    .done_id_i (own),
    .pick_o    (pick)
  );

  // A lock is honoured once per grant, so the other side waits at most one
  // extra transaction. Dropping cen while granted (lock idle cycle or an
  // abandoned access) always returns to IDLE without moving the pointer.
  always_comb begin
    state_d  = state_q;
    locked_d = locked_q;
    unique case (state_q)
      ST_IDLE: begin
        locked_d = 1'b0;
        if (pick[0])      state_d = ST_GNT0;
        else if (pick[1]) state_d = ST_GNT1;
      end
      ST_GNT0, ST_GNT1: begin
        if (!cen_sel) begin
          state_d  = ST_IDLE;
          locked_d = 1'b0;
        end else if (done) begin
          if (lock_sel && !locked_q) begin
            locked_d = 1'b1;
          end else begin
            state_d  = ST_IDLE;
            locked_d = 1'b0;
          end
        end
      end
      default: begin
        state_d  = ST_IDLE;
        locked_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      locked_q <= locked_d;
    end
  end

endmodule
